mem_sram_ctrl: RTL and testbench

- Parametrised on-chip SRAM slave for the RV32 SoC memory bus. It is the next generation of the single-port boot/data RAM.
- Same valid/ready/wstrb handshake to the CPU.
- Adds configurable depth, width and wait states, a registered response FSM, out-of-range detection with an error flag, and abort on chip-select loss.
- Sits behind the address decoder; one instance per RAM region (boot ROM image, scratch RAM).

---
 rtl/mem_sram_ctrl_pkg.sv | 25 ++
 rtl/mem_sram_ctrl_if.sv | 28 ++
 rtl/mem_sram_ctrl_sram.sv | 31 +++
 rtl/mem_sram_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_sram_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and helpers for the on-chip SRAM slave.
// FSM encoding, wait-counter width, clog2 and byte-lane count.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int WAIT_W = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// CPU memory-bus bundle: valid/ready/wstrb handshake plus region select.
// master = CPU/decoder side, slave = SRAM controller side.
interface mem_sram_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic                  io_enable;
  logic                  io_mem_valid;
  logic                  io_mem_instr;
  logic [DATA_W/8-1:0]   io_mem_wstrb;
  logic [DATA_W-1:0]     io_mem_wdata;
  logic [ADDR_W-1:0]     io_mem_addr;
  logic [DATA_W-1:0]     io_mem_rdata;
  logic                  io_mem_ready;
  logic                  io_mem_err;

  modport master (
    output io_enable, io_mem_valid, io_mem_instr,
    output io_mem_wstrb, io_mem_wdata, io_mem_addr,
    input  io_mem_rdata, io_mem_ready, io_mem_err
  );

  modport slave (
    input  io_enable, io_mem_valid, io_mem_instr,
    input  io_mem_wstrb, io_mem_wdata, io_mem_addr,
    output io_mem_rdata, io_mem_ready, io_mem_err
  );
endinterface

// File: rtl/mem_sram_ctrl_sram.sv
// Single-port synchronous RAM with byte enables (block-RAM template).
// Ports: clk, en, we[lanes], addr, wdata in; q out (registered read).
module sram_sp_be
  import mem_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 10240,
  parameter string INIT_FILE = "",
  localparam int   LANES     = lanes(DATA_W),
  localparam int   AW        = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [LANES-1:0]  we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_sram_ctrl.sv
// SRAM bus slave: request latch, range check, wait states, response FSM.
// Ports: clk, reset (async active-low), bus (mem_sram_ctrl_if.slave).
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = 16,
  parameter int    DEPTH       = 10240,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input logic            clk,
  input logic            reset,
  mem_sram_ctrl_if.slave bus
);

  localparam int LANES = lanes(DATA_W);
  localparam int OFS   = clog2(LANES);
  localparam int IW    = ADDR_W - OFS;
  localparam int AW    = clog2(DEPTH);

  state_t              state;
  logic [WAIT_W-1:0]   cnt;
  logic [IW-1:0]       idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [LANES-1:0]    wstrb_q;
  logic                instr_q;
  logic                oor_q;
  logic                ready_q;
  logic                err_q;

  logic [IW-1:0]       idx;
  logic                ram_en;
  logic [LANES-1:0]    ram_we;
  logic [DATA_W-1:0]   ram_q;
  logic                rd_ok;
  logic                unused_instr;

  assign idx          = bus.io_mem_addr[ADDR_W-1:OFS];
  assign unused_instr = instr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      oor_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.io_mem_valid && bus.io_enable) begin
            idx_q   <= idx;
            wdata_q <= bus.io_mem_wdata;
            wstrb_q <= bus.io_mem_wstrb;
            instr_q <= bus.io_mem_instr;
            oor_q   <= (int'(idx) >= DEPTH);
            state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!bus.io_enable) begin
            state <= S_IDLE;
          end else if (WAIT_STATES > 0) begin
            cnt   <= WAIT_W'(WAIT_STATES - 1);
            state <= S_WAIT;
          end else begin
            ready_q <= 1'b1;
            err_q   <= oor_q;
            state   <= S_RESP;
          end
        end
        S_WAIT: begin
          if (!bus.io_enable) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            ready_q <= 1'b1;
            err_q   <= oor_q;
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM is only touched in ACCESS; q then holds through WAIT/RESP.
  assign ram_en = (state == S_ACCESS) && !oor_q;
  assign ram_we = ram_en ? wstrb_q : '0;

  sram_sp_be #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (AW'(idx_q)),
    .wdata (wdata_q),
    .q     (ram_q)
  );

  // Bus is OR-able: drive zero except on a good read response.
  assign rd_ok            = ready_q && !oor_q && (wstrb_q == '0);
  assign bus.io_mem_rdata = rd_ok ? ram_q : '0;
  assign bus.io_mem_ready = ready_q;
  assign bus.io_mem_err   = err_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench: two controllers (0 and 3 wait states),
// directed cases plus randomized traffic against a word-array model.
module tb_mem_sram_ctrl;

  localparam int DEPTH = 10240;

  logic clk;
  logic reset;

  int checks;
  int failures;

  bit [31:0] model [int];

  mem_sram_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus0 ();
  mem_sram_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus1 ();

  mem_sram_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  mem_sram_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(3)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  logic        rdy_o   [2];
  logic        err_o   [2];
  logic [31:0] rdata_o [2];

  assign rdy_o[0]   = bus0.io_mem_ready;
  assign rdy_o[1]   = bus1.io_mem_ready;
  assign err_o[0]   = bus0.io_mem_err;
  assign err_o[1]   = bus1.io_mem_err;
  assign rdata_o[0] = bus0.io_mem_rdata;
  assign rdata_o[1] = bus1.io_mem_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic en, input logic v,
                       input logic [3:0] ws, input logic [31:0] wd,
                       input logic [15:0] ad);
    if (sel == 0) begin
      bus0.io_enable    = en;
      bus0.io_mem_valid = v;
      bus0.io_mem_instr = 1'($urandom);
      bus0.io_mem_wstrb = ws;
      bus0.io_mem_wdata = wd;
      bus0.io_mem_addr  = ad;
    end else begin
      bus1.io_enable    = en;
      bus1.io_mem_valid = v;
      bus1.io_mem_instr = 1'($urandom);
      bus1.io_mem_wstrb = ws;
      bus1.io_mem_wdata = wd;
      bus1.io_mem_addr  = ad;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Model update and expected read value for one request.
  task automatic predict(input int sel, input logic [15:0] addr,
                         input logic [3:0] ws, input logic [31:0] wd,
                         output bit oor, output logic [31:0] rd);
    int idx;
    int key;
    idx = int'(addr) / 4;
    key = sel * 65536 + idx;
    oor = (idx >= DEPTH);
    rd  = 32'h0;
    if (!oor) begin
      if (ws == 4'h0) begin
        rd = model.exists(key) ? model[key] : 32'h0;
      end else begin
        for (int i = 0; i < 4; i++)
          if (ws[i]) model[key][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endtask

  // Full transaction; starts and ends at a negedge with the DUT idle.
  task automatic txn(input int sel, input logic [15:0] addr,
                     input logic [3:0] ws, input logic [31:0] wd,
                     input bit hold);
    int lat;
    bit oor;
    logic [31:0] exp_rd;
    lat = (sel == 0) ? 2 : 5;
    predict(sel, addr, ws, wd, oor, exp_rd);
    drive(sel, 1'b1, 1'b1, ws, wd, addr);
    for (int n = 1; n <= lat; n++) begin
      step();
      chk("ready", 32'(rdy_o[sel]), 32'(n == lat));
      if (n < lat) begin
        chk("idle_rdata", rdata_o[sel], 32'h0);
        chk("idle_err", 32'(err_o[sel]), 32'h0);
      end else begin
        chk("err", 32'(err_o[sel]), 32'(oor));
        chk("rdata", rdata_o[sel], exp_rd);
      end
    end
    if (!hold) drive(sel, 1'b1, 1'b0, 4'h0, 32'h0, 16'h0);
    step();
    chk("single_ready", 32'(rdy_o[sel]), 32'h0);
    chk("post_rdata", rdata_o[sel], 32'h0);
    drive(sel, 1'b1, 1'b0, 4'h0, 32'h0, 16'h0);
  endtask

  int pool [2][8];

  initial begin
    bit          oor;
    logic [31:0] rd;
    int          sel;
    int          pidx;
    logic [15:0] a;
    logic [3:0]  ws;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(0, 1'b1, 1'b0, 4'h0, 32'h0, 16'h0);
    drive(1, 1'b1, 1'b0, 4'h0, 32'h0, 16'h0);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(rdy_o[s]), 32'h0);
      chk("rst_err", 32'(err_o[s]), 32'h0);
      chk("rst_rdata", rdata_o[s], 32'h0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    step();

    txn(0, 16'h0010, 4'hF, 32'hDEADBEEF, 1'b0);
    txn(0, 16'h0010, 4'h0, 32'h0, 1'b0);

    txn(0, 16'h0020, 4'hF, 32'h11223344, 1'b0);
    txn(0, 16'h0020, 4'h5, 32'hAABBCCDD, 1'b0);
    txn(0, 16'h0020, 4'h0, 32'h0, 1'b0);
    chk("strobe_model", model[16'h0020 / 4], 32'h11BB33DD);

    txn(0, 16'h9FFC, 4'hF, 32'h12345678, 1'b0);
    txn(0, 16'hA000, 4'hF, 32'hFFFFFFFF, 1'b0);
    txn(0, 16'h9FFC, 4'h0, 32'h0, 1'b0);
    txn(0, 16'hA000, 4'h0, 32'h0, 1'b0);

    txn(1, 16'h0000, 4'hF, 32'h0BADF00D, 1'b0);
    txn(1, 16'h0000, 4'h0, 32'h0, 1'b1);

    // Abort in WAIT: write commits, no response.
    txn(1, 16'h0040, 4'hF, 32'hCAFEF00D, 1'b0);
    predict(1, 16'h0040, 4'h1, 32'h00000055, oor, rd);
    drive(1, 1'b1, 1'b1, 4'h1, 32'h00000055, 16'h0040);
    step();
    chk("abort_acc_ready", 32'(rdy_o[1]), 32'h0);
    step();
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 16'h0);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("abort_ready", 32'(rdy_o[1]), 32'h0);
      chk("abort_err", 32'(err_o[1]), 32'h0);
    end
    drive(1, 1'b1, 1'b0, 4'h0, 32'h0, 16'h0);
    txn(1, 16'h0040, 4'h0, 32'h0, 1'b0);

    // Reset mid-WAIT, then reset while the response is on the bus.
    drive(1, 1'b1, 1'b1, 4'h0, 32'h0, 16'h0040);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rstw_ready", 32'(rdy_o[1]), 32'h0);
    chk("rstw_rdata", rdata_o[1], 32'h0);
    drive(1, 1'b1, 1'b0, 4'h0, 32'h0, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      step();
      chk("rstw_noready", 32'(rdy_o[1]), 32'h0);
    end
    drive(1, 1'b1, 1'b1, 4'h0, 32'h0, 16'h0040);
    for (int n = 0; n < 5; n++) step();
    chk("rstr_ready_before", 32'(rdy_o[1]), 32'h1);
    reset = 1'b0;
    #1;
    chk("rstr_ready", 32'(rdy_o[1]), 32'h0);
    chk("rstr_err", 32'(err_o[1]), 32'h0);
    chk("rstr_rdata", rdata_o[1], 32'h0);
    drive(1, 1'b1, 1'b0, 4'h0, 32'h0, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    txn(1, 16'h0040, 4'h0, 32'h0, 1'b0);
    txn(0, 16'h0010, 4'h0, 32'h0, 1'b0);

    // Randomized traffic over a small pool of known words per instance.
    for (int s = 0; s < 2; s++) begin
      pool[s][0] = 0;
      pool[s][1] = DEPTH - 1;
      for (int i = 2; i < 8; i++)
        pool[s][i] = int'($urandom_range(1, DEPTH - 2));
      for (int i = 0; i < 8; i++)
        txn(s, 16'(pool[s][i] * 4), 4'hF, $urandom, 1'b0);
    end
    for (int k = 0; k < 60; k++) begin
      sel  = int'($urandom_range(0, 1));
      pidx = int'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)
        a = 16'($urandom_range(DEPTH, 16383) * 4);
      else
        a = 16'(pool[sel][pidx] * 4);
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      txn(sel, a, ws, $urandom, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
